// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the shared data bus. The bus parks on the CPU (master 0).
// Master 1 gets bounded locked bursts and a starvation escape over master 0.
//
// state  | meaning
// OWN_M0 | CPU owns the bus; also the park state when nobody asks
// OWN_M1 | DMA / boot-loader port owns the bus
module data_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 15,
    parameter int MAX_BURST  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      m_req,
    input  logic [1:0]      m_wr,
    input  logic [1:0]      m_lock,
    input  logic [2*AW-1:0] m_addr,
    input  logic [2*DW-1:0] m_wdata,
    output logic [1:0]      m_gnt,
    output logic [1:0]      m_ack,
    output logic [DW-1:0]   m_rdata,
    output logic            bus_rd,
    output logic            bus_wr,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic [DW-1:0]   bus_rdata
);

    typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_t;

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [SW-1:0] STARVE_INIT = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BEAT_INIT   = BW'(MAX_BURST - 1);

    owner_t        state_q, state_d;
    logic [SW-1:0] starve_left_q, starve_left_d;
    logic [BW-1:0] beats_left_q, beats_left_d;
    logic [1:0]    gnt;
    logic          own1, xfer, other_req, lock_own, wr_own;
    logic          burst_tc, starved;

    assign own1      = (state_q == OWN_M1);
    assign xfer      = m_req[own1];
    assign other_req = m_req[~own1];
    assign lock_own  = m_lock[own1];
    assign wr_own    = m_wr[own1];
    assign burst_tc  = (beats_left_q == '0);
    // The starvation escape only counts while master 1 is actually waiting,
    // so a starved master 1 wins exactly one arbitration, not two.
    assign starved   = ~own1 & (starve_left_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OWN_M0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = OWN_M0;
        if (lock_own && xfer && (!burst_tc || !other_req)) begin
            state_d = state_q;
        end else if (m_req[1] && (!m_req[0] || starved)) begin
            state_d = OWN_M1;
        end
    end

    always_comb begin
        gnt    = own1 ? 2'b10 : 2'b01;
        m_gnt  = 2'b01;
        m_ack  = 2'b00;
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        if (!reset) begin
            m_gnt  = gnt;
            m_ack  = m_req & gnt;
            bus_rd = xfer & ~wr_own;
            bus_wr = xfer & wr_own;
        end
    end

    assign bus_addr  = own1 ? m_addr[2*AW-1:AW]  : m_addr[AW-1:0];
    assign bus_wdata = own1 ? m_wdata[2*DW-1:DW] : m_wdata[DW-1:0];
    assign m_rdata   = bus_rdata;

    // Both timers count down to a terminal count of zero.
    always_comb begin
        starve_left_d = starve_left_q;
        if (!m_req[1] || own1) begin
            starve_left_d = STARVE_INIT;
        end else if (!starved) begin
            starve_left_d = starve_left_q - SW'(1);
        end

        beats_left_d = beats_left_q;
        if (state_d != state_q) begin
            beats_left_d = BEAT_INIT;
        end else if (xfer && lock_own) begin
            if (!burst_tc) begin
                beats_left_d = beats_left_q - BW'(1);
            end
        end else if (xfer) begin
            beats_left_d = BEAT_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_left_q <= STARVE_INIT;
            beats_left_q  <= BEAT_INIT;
        end else begin
            starve_left_q <= starve_left_d;
            beats_left_q  <= beats_left_d;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Testbench for data_bus_arbiter: directed vector table, hand-written burst and
// starvation sequences, then randomized traffic against a behavioural model.
module tb_data_bus_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 15;
    localparam int MAX_BURST  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      m_req, m_wr, m_lock;
    logic [31:0]     a0, a1, wd0, wd1;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [1:0]      m_gnt, m_ack;
    logic [DW-1:0]   m_rdata;
    logic            bus_rd, bus_wr;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [DW-1:0]   bus_rdata;

    assign m_addr  = {a1, a0};
    assign m_wdata = {wd1, wd0};

    always #5 clk = ~clk;

    data_bus_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_lock(m_lock),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_ack(m_ack),
        .m_rdata(m_rdata), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, how long master 1 has been kept
    // waiting, and how many locked beats the current owner has taken.
    int mo_owner = 0;
    int mo_wait  = 0;
    int mo_beats = 0;

    typedef struct packed {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [1:0]  lock;
        logic [1:0]  e_gnt;
        logic [1:0]  e_ack;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void model_step();
        int  nown;
        bit  xfer, other;
        if (reset) begin
            mo_owner = 0;
            mo_wait  = 0;
            mo_beats = 0;
            return;
        end
        xfer  = m_req[mo_owner];
        other = m_req[1 - mo_owner];
        if (m_lock[mo_owner] && xfer && (mo_beats < MAX_BURST - 1 || !other))
            nown = mo_owner;
        else if (m_req[1] && (!m_req[0] || (mo_owner == 0 && mo_wait == STARVE_MAX)))
            nown = 1;
        else
            nown = 0;
        if (!m_req[1] || mo_owner == 1) mo_wait = 0;
        else if (mo_wait < STARVE_MAX) mo_wait++;
        if (nown != mo_owner) mo_beats = 0;
        else if (xfer && m_lock[mo_owner]) begin
            if (mo_beats < MAX_BURST - 1) mo_beats++;
        end else if (xfer) mo_beats = 0;
        mo_owner = nown;
    endfunction

    function automatic logic [101:0] model_exp();
        logic [1:0] g, a;
        logic       x, w;
        g = reset ? 2'b01 : ((mo_owner == 1) ? 2'b10 : 2'b01);
        a = reset ? 2'b00 : (m_req & g);
        x = !reset && m_req[mo_owner];
        w = m_wr[mo_owner];
        return {g, a, x && !w, x && w, (mo_owner == 1) ? a1 : a0,
                (mo_owner == 1) ? wd1 : wd0, bus_rdata};
    endfunction

    function automatic logic [101:0] actual();
        return {m_gnt, m_ack, bus_rd, bus_wr, bus_addr, bus_wdata, m_rdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc_check(input string name, input logic [1:0] eg, input logic [1:0] ea,
                             input logic erd, input logic ewr);
        @(negedge clk);
        chk(name, {m_gnt, m_ack, bus_rd, bus_wr}, {eg, ea, erd, ewr});
        tick();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        m_req  = 2'b00;
        m_lock = 2'b00;
        m_wr   = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        m_req     = 2'b00;
        m_wr      = 2'b00;
        m_lock    = 2'b00;
        a0        = 32'h4000000C;
        a1        = 32'h00001000;
        wd0       = 32'hDEADBEEF;
        wd1       = 32'hFFFFFFFF;
        bus_rdata = 32'h12345678;

        //                rst  req    wr     lock   gnt    ack    rd    wr    addr          wdata
        vecs[0]  = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'h4000000C, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 32'h4000000C, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 32'h4000000C, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'h4000000C, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 32'h00001000, 32'hFFFFFFFF};
        vecs[5]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 32'h00001000, 32'hFFFFFFFF};
        vecs[6]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'h4000000C, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 32'h4000000C, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'h4000000C, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 32'h00001000, 32'hFFFFFFFF};
        vecs[10] = '{1'b1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'h00001000, 32'hFFFFFFFF};
        vecs[11] = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'h4000000C, 32'hDEADBEEF};

        #1;
        tick();
        tick();

        for (int i = 0; i < 12; i++) begin
            reset  = vecs[i].rst;
            m_req  = vecs[i].req;
            m_wr   = vecs[i].wr;
            m_lock = vecs[i].lock;
            @(negedge clk);
            chk($sformatf("vec%0d", i), actual(),
                {vecs[i].e_gnt, vecs[i].e_ack, vecs[i].e_rd, vecs[i].e_wr,
                 vecs[i].e_addr, vecs[i].e_wdata, 32'h12345678});
            tick();
        end

        // Both masters hold requests: 16 CPU transfers, then exactly one for master 1.
        do_reset();
        m_req = 2'b11;
        for (int c = 0; c < 51; c++) begin
            if (c % 17 == 16)
                cyc_check($sformatf("starve_c%0d", c), 2'b10, 2'b10, 1'b1, 1'b0);
            else
                cyc_check($sformatf("starve_c%0d", c), 2'b01, 2'b01, 1'b1, 1'b0);
        end

        // Locked 12-beat write burst with the CPU idle.
        do_reset();
        m_req  = 2'b10;
        m_lock = 2'b10;
        m_wr   = 2'b10;
        cyc_check("burst12_arb", 2'b01, 2'b00, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++)
            cyc_check($sformatf("burst12_b%0d", c), 2'b10, 2'b10, 1'b0, 1'b1);
        m_req  = 2'b00;
        m_lock = 2'b00;
        cyc_check("burst12_drop", 2'b10, 2'b00, 1'b0, 1'b0);
        cyc_check("burst12_park", 2'b01, 2'b00, 1'b0, 1'b0);

        // CPU arrives at beat 3: master 1 is cut off after MAX_BURST beats.
        do_reset();
        m_lock = 2'b10;
        for (int c = 0; c <= 9; c++) begin
            m_req = {1'b1, (c >= 3)};
            if (c == 0)
                cyc_check("cut_arb", 2'b01, 2'b00, 1'b0, 1'b0);
            else if (c <= MAX_BURST)
                cyc_check($sformatf("cut_b%0d", c), 2'b10, 2'b10, 1'b1, 1'b0);
            else
                cyc_check("cut_cpu", 2'b01, 2'b01, 1'b1, 1'b0);
        end

        // Reset pulsed at beat 4 of a locked write burst.
        do_reset();
        m_req  = 2'b10;
        m_lock = 2'b10;
        m_wr   = 2'b10;
        cyc_check("rstb_arb", 2'b01, 2'b00, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++)
            cyc_check($sformatf("rstb_b%0d", c), 2'b10, 2'b10, 1'b0, 1'b1);
        reset = 1'b1;
        cyc_check("rstb_in0", 2'b01, 2'b00, 1'b0, 1'b0);
        cyc_check("rstb_in1", 2'b01, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        cyc_check("rstb_after", 2'b01, 2'b00, 1'b0, 1'b0);
        cyc_check("rstb_regrant", 2'b10, 2'b10, 1'b0, 1'b1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) m_req[0] = ~m_req[0];
            if ($urandom_range(0, 7) == 0) m_req[1] = ~m_req[1];
            m_wr      = 2'($urandom_range(0, 3));
            m_lock[0] = ($urandom_range(0, 2) == 0);
            m_lock[1] = ($urandom_range(0, 3) != 0);
            a0        = $urandom;
            a1        = $urandom;
            wd0       = $urandom;
            wd1       = $urandom;
            bus_rdata = $urandom;
            @(negedge clk);
            chk($sformatf("rand_c%0d", c), actual(), model_exp());
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
